difftest_commit_unit: RTL
=========================

# difftest_commit_unit

Parametrised commit and trap tracker for multi-issue cores. It sits between the core's retire ports and the Difftest DPI blocks (InstrCommit per channel, TrapEvent). Each cycle it registers up to COMMIT_W retirements, filters writes to x0, and maintains cycle and instruction counters. It detects the trap instruction, squashes younger channels, captures the trap code with same-cycle a0 bypass, and halts.

## Interface
- XLEN, 64, data and PC width.
- COMMIT_W, 2, number of commit channels (1..4); channel 0 is oldest.
- TRAP_OPCODE, 7'h6b, inst[6:0] value that signals end of test.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  COMMIT_W  per-channel retire valid.
- in_pc  in  COMMIT_W*XLEN  retired PC; channel i at [i*XLEN +: XLEN].
- in_inst  in  COMMIT_W*32  retired instruction.
- in_wen  in  COMMIT_W  register write enable.
- in_wdest  in  COMMIT_W*5  destination register.
- in_wdata  in  COMMIT_W*XLEN  write data.
- in_skip  in  COMMIT_W  MMIO/skip flag, passed through.
- a0_i  in  XLEN  architectural x10 before this cycle's retirements.
- cmt_valid  out  COMMIT_W  registered commit valid.
- cmt_pc, cmt_inst, cmt_wdata  out  per-channel packed  registered copies.
- cmt_wen  out  COMMIT_W  registered write enable, forced 0 when wdest==0.
- cmt_wdest  out  COMMIT_W*8  {3'b0, wdest}.
- cmt_skip  out  COMMIT_W  registered skip.
- trap_valid  out  1  high from trap capture until reset.
- trap_code  out  8  captured a0[7:0].
- trap_pc  out  XLEN  PC of the trapping instruction.
- cycle_cnt, instr_cnt  out  64  free-running counters.
- order_err  out  1  sticky; in_valid was not a contiguous prefix.

## Operation
- States: RUN and HALT. Reset enters RUN. All outputs, counters, and order_err reset to 0.
- Accepted set: the longest contiguous run of in_valid ones starting at channel 0. Valid channels after the first gap are dropped, and order_err is set. order_err stays set until reset.
- Trap detection in RUN: k is the lowest accepted channel with in_inst[6:0]==TRAP_OPCODE. Channels 0..k commit; channels above k are squashed. If no accepted channel traps, every accepted channel commits.
- For each committed channel i, the next edge loads cmt_valid[i]=1 and the pc, inst, wdata, and skip fields. It loads cmt_wen[i]=in_wen[i]&(wdest!=0). Non-committed channels load cmt_valid=0, with their other fields also loaded as 0.
- instr_cnt += popcount(committed channels). The trap instruction itself is counted.
- cycle_cnt += 1 every cycle in RUN, including the trap cycle.
- Both counters are 64 bits and wrap modulo 2^64.
- Trap capture, in the same edge as the commit: trap_valid<=1, trap_pc<=in_pc[k], next state HALT.
  - trap_code<=wdata[7:0] of the highest channel j<k with wen & wdest==10.
  - If no such channel exists, trap_code<=a0_i[7:0].
- HALT:
  - cmt_valid goes all 0 and cmt_wen goes all 0.
  - Counters, trap_code, and trap_pc are frozen.
  - Inputs are ignored, and order_err does not update.
  - Only reset leaves HALT.
- A trap on a channel that is dropped by the prefix rule is not detected.

## Timing
- Latency: 1 cycle from inputs to cmt_* and trap_* outputs. Inputs are registered with no combinational path to any output.
- trap_valid and the trapping instruction's cmt_valid assert on the same edge.
- cmt_valid is zero on the first edge in HALT. In HALT, trap_valid is held every cycle until reset.
- Reset has priority at every edge, including mid-trap. After reset deasserts, outputs are zero and the first capture happens on the next edge.
- cycle_cnt equals the number of RUN edges since reset; the first non-reset edge gives 1.

## Test plan
- COMMIT_W=2, in_valid=2'b11, wdest0=0 with wen0=1, wdest1=5, wdata1=0x1234 -> next edge cmt_valid=11, cmt_wen=2'b10, cmt_wdest1=8'd5, instr_cnt=2, cycle_cnt=1.
- in_valid=2'b10 -> cmt_valid=00, order_err=1 (stays 1 afterwards), instr_cnt unchanged.
- Channel 0 inst=0x0000006b, a0_i=0x2A, channel 1 valid -> cmt_valid=01, trap_valid=1, trap_code=0x2A, trap_pc=in_pc0. Next edge cmt_valid=00 and counters frozen for 10 cycles.
- Channel 0 writes x10=0x...FF01, channel 1 traps, a0_i=0x07 -> trap_code=0x01, instr_cnt +2.
- instr_cnt preset near wrap via 2^64-1 path (force), commit 2 -> wraps to 1, no side effect on trap.
- Assert reset for one cycle while in HALT -> all outputs 0, state RUN. A normal commit on the following edge is accepted.

Source files
------------

// File: rtl/difftest_commit_unit_if.sv
// Retire-side bundle for difftest_commit_unit: per-channel retire inputs from the core
// and the registered commit/trap/counter view consumed by the Difftest blocks.
interface difftest_commit_unit_if #(
   parameter int XLEN     = 64,
   parameter int COMMIT_W = 2
);
   // Valid-only protocol: there is no ready; every cycle the unit samples in_valid and
   // the enabled channels, and one cycle later presents cmt_valid for what it committed.
   logic [COMMIT_W-1:0]      in_valid;
   logic [COMMIT_W*XLEN-1:0] in_pc;
   logic [COMMIT_W*32-1:0]   in_inst;
   logic [COMMIT_W-1:0]      in_wen;
   logic [COMMIT_W*5-1:0]    in_wdest;
   logic [COMMIT_W*XLEN-1:0] in_wdata;
   logic [COMMIT_W-1:0]      in_skip;
   logic [XLEN-1:0]          a0_i;

   logic [COMMIT_W-1:0]      cmt_valid;
   logic [COMMIT_W*XLEN-1:0] cmt_pc;
   logic [COMMIT_W*32-1:0]   cmt_inst;
   logic [COMMIT_W*XLEN-1:0] cmt_wdata;
   logic [COMMIT_W-1:0]      cmt_wen;
   logic [COMMIT_W*8-1:0]    cmt_wdest;
   logic [COMMIT_W-1:0]      cmt_skip;
   logic                     trap_valid;
   logic [7:0]               trap_code;
   logic [XLEN-1:0]          trap_pc;
   logic [63:0]              cycle_cnt;
   logic [63:0]              instr_cnt;
   logic                     order_err;
   logic                     dbg_halt;

   modport master (
      output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, a0_i,
      input  cmt_valid, cmt_pc, cmt_inst, cmt_wdata, cmt_wen, cmt_wdest, cmt_skip,
      input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, order_err, dbg_halt
   );

   modport slave (
      input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, a0_i,
      output cmt_valid, cmt_pc, cmt_inst, cmt_wdata, cmt_wen, cmt_wdest, cmt_skip,
      output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, order_err, dbg_halt
   );
endinterface

// File: rtl/difftest_commit_unit.sv
// Commit and trap tracker: registers in-order retirements, counts cycles/instructions,
// detects the end-of-test trap, captures its code (with same-cycle a0 bypass) and halts.
module difftest_commit_unit #(
   parameter int         XLEN        = 64,
   parameter int         COMMIT_W    = 2,
   parameter logic [6:0] TRAP_OPCODE = 7'h6b
) (
   input  logic                  clock,
   input  logic                  reset,
   difftest_commit_unit_if.slave bus
);
   localparam int W = COMMIT_W;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [W-1:0]          cmt_valid_q, cmt_valid_d;
   logic [W*XLEN-1:0]     cmt_pc_q, cmt_pc_d;
   logic [W*32-1:0]       cmt_inst_q, cmt_inst_d;
   logic [W*XLEN-1:0]     cmt_wdata_q, cmt_wdata_d;
   logic [W-1:0]          cmt_wen_q, cmt_wen_d;
   logic [W*8-1:0]        cmt_wdest_q, cmt_wdest_d;
   logic [W-1:0]          cmt_skip_q, cmt_skip_d;
   logic                  trap_valid_q, trap_valid_d;
   logic [7:0]            trap_code_q, trap_code_d;
   logic [XLEN-1:0]       trap_pc_q, trap_pc_d;
   logic [63:0]           cycle_cnt_q, cycle_cnt_d;
   logic [63:0]           instr_cnt_q, instr_cnt_d;
   logic                  order_err_q, order_err_d;

   logic [W-1:0]          accepted;
   logic [W-1:0]          commit;
   logic                  trap_found;
   logic [7:0]            trap_code_sel;
   logic [XLEN-1:0]       trap_pc_sel;
   logic [63:0]           n_commit;

   always_comb begin
      logic run;
      run           = 1'b1;
      accepted      = '0;
      commit        = '0;
      trap_found    = 1'b0;
      trap_code_sel = bus.a0_i[7:0];
      trap_pc_sel   = '0;
      n_commit      = '0;

      // Walk oldest to youngest; a later x10 write overrides an earlier one, so the
      // youngest write older than the trap wins the a0 bypass.
      for (int i = 0; i < W; i++) begin
         run         = run & bus.in_valid[i];
         accepted[i] = run;
         if (accepted[i] && !trap_found) begin
            commit[i] = 1'b1;
            n_commit  = n_commit + 64'd1;
            if (bus.in_inst[i*32 +: 7] == TRAP_OPCODE) begin
               trap_found  = 1'b1;
               trap_pc_sel = bus.in_pc[i*XLEN +: XLEN];
            end else if (bus.in_wen[i] && (bus.in_wdest[i*5 +: 5] == 5'd10)) begin
               trap_code_sel = bus.in_wdata[i*XLEN +: 8];
            end
         end
      end

      state_d      = state_q;
      cmt_valid_d  = '0;
      cmt_pc_d     = '0;
      cmt_inst_d   = '0;
      cmt_wdata_d  = '0;
      cmt_wen_d    = '0;
      cmt_wdest_d  = '0;
      cmt_skip_d   = '0;
      trap_valid_d = trap_valid_q;
      trap_code_d  = trap_code_q;
      trap_pc_d    = trap_pc_q;
      cycle_cnt_d  = cycle_cnt_q;
      instr_cnt_d  = instr_cnt_q;
      order_err_d  = order_err_q;

      if (state_q == RUN) begin
         for (int i = 0; i < W; i++) begin
            if (commit[i]) begin
               cmt_valid_d[i]              = 1'b1;
               cmt_pc_d[i*XLEN +: XLEN]    = bus.in_pc[i*XLEN +: XLEN];
               cmt_inst_d[i*32 +: 32]      = bus.in_inst[i*32 +: 32];
               cmt_wdata_d[i*XLEN +: XLEN] = bus.in_wdata[i*XLEN +: XLEN];
               cmt_wen_d[i]                = bus.in_wen[i] & (bus.in_wdest[i*5 +: 5] != 5'd0);
               cmt_wdest_d[i*8 +: 8]       = {3'b000, bus.in_wdest[i*5 +: 5]};
               cmt_skip_d[i]               = bus.in_skip[i];
            end
         end
         cycle_cnt_d = cycle_cnt_q + 64'd1;
         instr_cnt_d = instr_cnt_q + n_commit;
         if (bus.in_valid != accepted) begin
            order_err_d = 1'b1;
         end
         if (trap_found) begin
            trap_valid_d = 1'b1;
            trap_code_d  = trap_code_sel;
            trap_pc_d    = trap_pc_sel;
            state_d      = HALT;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= RUN;
         cmt_valid_q  <= '0;
         cmt_pc_q     <= '0;
         cmt_inst_q   <= '0;
         cmt_wdata_q  <= '0;
         cmt_wen_q    <= '0;
         cmt_wdest_q  <= '0;
         cmt_skip_q   <= '0;
         trap_valid_q <= 1'b0;
         trap_code_q  <= '0;
         trap_pc_q    <= '0;
         cycle_cnt_q  <= '0;
         instr_cnt_q  <= '0;
         order_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmt_valid_q  <= cmt_valid_d;
         cmt_pc_q     <= cmt_pc_d;
         cmt_inst_q   <= cmt_inst_d;
         cmt_wdata_q  <= cmt_wdata_d;
         cmt_wen_q    <= cmt_wen_d;
         cmt_wdest_q  <= cmt_wdest_d;
         cmt_skip_q   <= cmt_skip_d;
         trap_valid_q <= trap_valid_d;
         trap_code_q  <= trap_code_d;
         trap_pc_q    <= trap_pc_d;
         cycle_cnt_q  <= cycle_cnt_d;
         instr_cnt_q  <= instr_cnt_d;
         order_err_q  <= order_err_d;
      end
   end

   assign bus.cmt_valid  = cmt_valid_q;
   assign bus.cmt_pc     = cmt_pc_q;
   assign bus.cmt_inst   = cmt_inst_q;
   assign bus.cmt_wdata  = cmt_wdata_q;
   assign bus.cmt_wen    = cmt_wen_q;
   assign bus.cmt_wdest  = cmt_wdest_q;
   assign bus.cmt_skip   = cmt_skip_q;
   assign bus.trap_valid = trap_valid_q;
   assign bus.trap_code  = trap_code_q;
   assign bus.trap_pc    = trap_pc_q;
   assign bus.cycle_cnt  = cycle_cnt_q;
   assign bus.instr_cnt  = instr_cnt_q;
   assign bus.order_err  = order_err_q;
   assign bus.dbg_halt   = (state_q == HALT);
endmodule
